qpu_exu_bjp_rslv: RTL and testbench

Registered, parametrised conditional-branch resolution unit for the QPU execution stage. It carries its own XLEN-wide comparator rather than sharing the ALU datapath, and adds a signed/unsigned compare mode. It holds the result in a one-entry output pipeline register with a valid/ready handshake, flags mispredictions, raises a flush pulse and keeps saturating statistics counters. It sits between the dispatch/ALU issue point and the commit unit.

---
 rtl/qpu_exu_bjp_rslv.sv | 131 +++++++++++++
 tb/tb_qpu_exu_bjp_rslv.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_bjp_rslv.sv
// Branch resolution unit: compares the operands, registers the taken/predicted result behind a
// one-entry valid/ready stage, pulses flush on committed mispredictions and keeps saturating counters.
module qpu_exu_bjp_rslv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bjp_i_valid,
  output logic             bjp_i_ready,
  input  logic [XLEN-1:0]  bjp_i_rs1,
  input  logic [XLEN-1:0]  bjp_i_rs2,
  input  logic [5:0]       bjp_i_info,
  input  logic [TAG_W-1:0] bjp_i_tag,
  input  logic             bjp_i_kill,
  output logic             bjp_o_valid,
  input  logic             bjp_o_ready,
  output logic             bjp_o_cmt_prdt,
  output logic             bjp_o_cmt_rslv,
  output logic             bjp_o_mispred,
  output logic [TAG_W-1:0] bjp_o_tag,
  output logic             bjp_o_flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bjp_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int INFO_BPRDT = 0;
  localparam int INFO_BEQ   = 1;
  localparam int INFO_BNE   = 2;
  localparam int INFO_BLT   = 3;
  localparam int INFO_BGT   = 4;
  localparam int INFO_UNSGN = 5;

  // Signed compares reuse the unsigned comparator with the sign bits inverted.
  logic            sign_flip;
  logic [XLEN-1:0] op1_key;
  logic [XLEN-1:0] op2_key;
  logic            cmp_eq;
  logic            cmp_lt;
  logic            cmp_gt;
  logic            rslv_next;
  logic            prdt_next;

  assign sign_flip = ~bjp_i_info[INFO_UNSGN];
  assign op1_key   = {bjp_i_rs1[XLEN-1] ^ sign_flip, bjp_i_rs1[XLEN-2:0]};
  assign op2_key   = {bjp_i_rs2[XLEN-1] ^ sign_flip, bjp_i_rs2[XLEN-2:0]};
  assign cmp_eq    = (bjp_i_rs1 == bjp_i_rs2);
  assign cmp_lt    = (op1_key < op2_key);
  assign cmp_gt    = (op1_key > op2_key);
  assign prdt_next = bjp_i_info[INFO_BPRDT];
  assign rslv_next = (bjp_i_info[INFO_BEQ] &  cmp_eq)
                   | (bjp_i_info[INFO_BNE] & ~cmp_eq)
                   | (bjp_i_info[INFO_BLT] &  cmp_lt)
                   | (bjp_i_info[INFO_BGT] &  cmp_gt);

  logic             valid_reg;
  logic             valid_next;
  logic             prdt_reg;
  logic             rslv_reg;
  logic             mispred_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             flush_reg;
  logic             accept;
  logic             commit;

  assign bjp_i_ready = ~bjp_i_kill & (~valid_reg | bjp_o_ready);
  assign accept      = bjp_i_valid & bjp_i_ready;
  assign commit      = valid_reg & bjp_o_ready;

  // Kill wins over a new load; the entry committing in the kill cycle still counts.
  always_comb begin
    valid_next = valid_reg;
    if (bjp_i_kill) begin
      valid_next = 1'b0;
    end else if (accept) begin
      valid_next = 1'b1;
    end else if (commit) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      prdt_reg    <= 1'b0;
      rslv_reg    <= 1'b0;
      mispred_reg <= 1'b0;
      tag_reg     <= '0;
      flush_reg   <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      flush_reg <= commit & mispred_reg;
      if (accept) begin
        prdt_reg    <= prdt_next;
        rslv_reg    <= rslv_next;
        mispred_reg <= prdt_next ^ rslv_next;
        tag_reg     <= bjp_i_tag;
      end
    end
  end

  assign bjp_o_valid    = valid_reg;
  assign bjp_o_cmt_prdt = prdt_reg;
  assign bjp_o_cmt_rslv = rslv_reg;
  assign bjp_o_mispred  = mispred_reg;
  assign bjp_o_tag      = tag_reg;
  assign bjp_o_flush    = flush_reg;

  // Counter 0 counts committed branches, counter 1 committed mispredictions.
  logic [1:0] cnt_inc;
  assign cnt_inc = {commit & mispred_reg, commit};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bjp_cnt     = g_cnt[0].cnt_reg;
  assign mispred_cnt = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_qpu_exu_bjp_rslv.sv
// Scoreboard bench for qpu_exu_bjp_rslv (CNT_W=2 so counter saturation is reached quickly).
module tb_qpu_exu_bjp_rslv;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bjp_i_valid;
  logic             bjp_i_ready;
  logic [XLEN-1:0]  bjp_i_rs1;
  logic [XLEN-1:0]  bjp_i_rs2;
  logic [5:0]       bjp_i_info;
  logic [TAG_W-1:0] bjp_i_tag;
  logic             bjp_i_kill;
  logic             bjp_o_valid;
  logic             bjp_o_ready;
  logic             bjp_o_cmt_prdt;
  logic             bjp_o_cmt_rslv;
  logic             bjp_o_mispred;
  logic [TAG_W-1:0] bjp_o_tag;
  logic             bjp_o_flush;
  logic             cnt_clr;
  logic [CNT_W-1:0] bjp_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  qpu_exu_bjp_rslv #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .bjp_i_valid(bjp_i_valid), .bjp_i_ready(bjp_i_ready),
    .bjp_i_rs1(bjp_i_rs1), .bjp_i_rs2(bjp_i_rs2),
    .bjp_i_info(bjp_i_info), .bjp_i_tag(bjp_i_tag), .bjp_i_kill(bjp_i_kill),
    .bjp_o_valid(bjp_o_valid), .bjp_o_ready(bjp_o_ready),
    .bjp_o_cmt_prdt(bjp_o_cmt_prdt), .bjp_o_cmt_rslv(bjp_o_cmt_rslv),
    .bjp_o_mispred(bjp_o_mispred), .bjp_o_tag(bjp_o_tag), .bjp_o_flush(bjp_o_flush),
    .cnt_clr(cnt_clr), .bjp_cnt(bjp_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             prdt;
    logic             rslv;
    logic             mis;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             sb_q[$];
  logic             exp_valid = 1'b0;
  logic             exp_flush = 1'b0;
  logic [CNT_W-1:0] exp_bjp   = '0;
  logic [CNT_W-1:0] exp_mis   = '0;
  int               n_cmp = 0;
  int               n_err = 0;
  logic             rand_rdy = 1'b0;
  logic             rand_kill = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_rslv(input logic [5:0] info, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    logic eq, lt, gt;
    eq = (a == b);
    lt = info[5] ? (a < b) : ($signed(a) < $signed(b));
    gt = info[5] ? (a > b) : ($signed(a) > $signed(b));
    return (info[1] & eq) | (info[2] & ~eq) | (info[3] & lt) | (info[4] & gt);
  endfunction

  // Monitor: checks the state produced by the last edge, then predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", bjp_o_valid, 0);
      check("rst_prdt", bjp_o_cmt_prdt, 0);
      check("rst_rslv", bjp_o_cmt_rslv, 0);
      check("rst_mispred", bjp_o_mispred, 0);
      check("rst_tag", bjp_o_tag, 0);
      check("rst_flush", bjp_o_flush, 0);
      check("rst_bjp_cnt", bjp_cnt, 0);
      check("rst_mis_cnt", mispred_cnt, 0);
      sb_q.delete();
      exp_valid = 1'b0;
      exp_flush = 1'b0;
      exp_bjp   = '0;
      exp_mis   = '0;
    end else begin
      logic commit, accept, mis_head;
      ent_t e;
      check("o_valid", bjp_o_valid, exp_valid);
      check("flush", bjp_o_flush, exp_flush);
      check("bjp_cnt", bjp_cnt, exp_bjp);
      check("mispred_cnt", mispred_cnt, exp_mis);
      check("i_ready", bjp_i_ready, !bjp_i_kill && (!exp_valid || bjp_o_ready));
      mis_head = 1'b0;
      if (exp_valid) begin
        if (sb_q.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          check("prdt", bjp_o_cmt_prdt, sb_q[0].prdt);
          check("rslv", bjp_o_cmt_rslv, sb_q[0].rslv);
          check("mispred", bjp_o_mispred, sb_q[0].mis);
          check("tag", bjp_o_tag, sb_q[0].tag);
          mis_head = sb_q[0].mis;
        end
      end
      commit = exp_valid && bjp_o_ready;
      accept = bjp_i_valid && !bjp_i_kill && (!exp_valid || bjp_o_ready);
      if (commit)
        $display("commit tag=%0d prdt=%0b rslv=%0b mispred=%0b", bjp_o_tag, bjp_o_cmt_prdt,
                 bjp_o_cmt_rslv, bjp_o_mispred);
      exp_flush = commit && mis_head;
      if (cnt_clr) begin
        exp_bjp = '0;
        exp_mis = '0;
      end else if (commit) begin
        if (exp_bjp != CNT_MAX) exp_bjp = exp_bjp + 1'b1;
        if (mis_head && exp_mis != CNT_MAX) exp_mis = exp_mis + 1'b1;
      end
      if (exp_valid && (commit || bjp_i_kill) && sb_q.size() > 0) void'(sb_q.pop_front());
      if (accept) begin
        e.prdt = bjp_i_info[0];
        e.rslv = model_rslv(bjp_i_info, bjp_i_rs1, bjp_i_rs2);
        e.mis  = e.prdt ^ e.rslv;
        e.tag  = bjp_i_tag;
        sb_q.push_back(e);
      end
      exp_valid = bjp_i_kill ? 1'b0 : (accept ? 1'b1 : (commit ? 1'b0 : exp_valid));
    end
  end

  task automatic set_in(input logic [5:0] info, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
    bjp_i_valid = 1'b1;
    bjp_i_info  = info;
    bjp_i_rs1   = a;
    bjp_i_rs2   = b;
    bjp_i_tag   = tag;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until it is accepted, bounded by a cycle budget.
  task automatic send(input logic [5:0] info, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    logic acc;
    set_in(info, a, b, tag);
    for (int n = 0; ; n++) begin
      if (n >= 60) begin
        $display("FAIL send_timeout: tag %0d not accepted after %0d cycles", tag, n);
        $fatal(1, "request stuck");
      end
      if (rand_rdy) bjp_o_ready = 1'($urandom_range(0, 1));
      if (rand_kill) bjp_i_kill = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      acc = bjp_i_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bjp_i_valid = 1'b0;
    bjp_i_kill  = 1'b0;
  endtask

  localparam logic [5:0] I_BEQ = 6'b000010, I_BNE = 6'b000100, I_BLT = 6'b001000;
  localparam logic [5:0] I_BGT = 6'b010000, I_UNS = 6'b100000, I_PRD = 6'b000001;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    bjp_i_valid = 1'b0; bjp_i_rs1 = '0; bjp_i_rs2 = '0; bjp_i_info = '0; bjp_i_tag = '0;
    bjp_i_kill = 1'b0; bjp_o_ready = 1'b1; cnt_clr = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Signed BLT -1 < 1 mispredicted, then the unsigned variant resolves not-taken.
    send(I_BLT, 32'hFFFF_FFFF, 32'h0000_0001, 4'd1);
    tick(3);
    send(I_BLT | I_UNS, 32'hFFFF_FFFF, 32'h0000_0001, 4'd2);
    tick(3);

    // Back-to-back BEQ/BNE, tags 1..8, commit ready throughout.
    for (int t = 1; t <= 8; t++) begin
      ra = $urandom; rb = (t % 3 == 0) ? ra : $urandom;
      send(((t % 2) ? I_BEQ : I_BNE) | ((t % 4 == 1) ? I_PRD : 6'b0), ra, rb, 4'(t));
    end
    tick(3);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    tick(1);

    // Stall while full, then commit and reload in the same cycle.
    bjp_o_ready = 1'b0;
    send(I_BGT, 32'h7FFF_FFFF, 32'h8000_0000, 4'd9);
    set_in(I_BGT | I_UNS, 32'h7FFF_FFFF, 32'h8000_0000, 4'd10);
    tick(3);
    bjp_o_ready = 1'b1;
    tick(1);
    bjp_i_valid = 1'b0;
    tick(3);

    // Kill while full with a pending request: nothing accepted, no flush, counters unchanged.
    bjp_o_ready = 1'b0;
    send(I_BEQ | I_PRD, 32'd5, 32'd6, 4'd11);
    set_in(I_BNE, 32'd5, 32'd6, 4'd12);
    bjp_i_kill = 1'b1;
    tick(1);
    bjp_i_kill = 1'b0; bjp_i_valid = 1'b0; bjp_o_ready = 1'b1;
    tick(3);

    // Saturation: five mispredicted commits, then a clear colliding with a commit.
    for (int k = 0; k < 5; k++) send(I_BEQ | I_PRD, 32'(k), 32'(k + 1), 4'(k));
    tick(3);
    send(I_BNE, 32'd1, 32'd2, 4'd7);
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0;
    tick(3);

    // Random operations, including multi-bit and empty op fields, random back-pressure and kills.
    rand_rdy = 1'b1; rand_kill = 1'b1;
    for (int k = 0; k < 40; k++) begin
      ra = (k % 5 == 0) ? 32'h8000_0000 : $urandom;
      rb = (k % 7 == 0) ? ra : ((k % 5 == 1) ? 32'h7FFF_FFFF : $urandom);
      send(6'($urandom), ra, rb, 4'(k));
    end
    rand_rdy = 1'b0; rand_kill = 1'b0; bjp_o_ready = 1'b1;
    tick(3);

    // Reset while holding a mispredicted entry: dropped at once, no flush afterwards.
    bjp_o_ready = 1'b0;
    send(I_BNE, 32'd3, 32'd4, 4'd13);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1; bjp_o_ready = 1'b1;
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
